// File: rtl/vga_pattern_ctrl_if.sv
// Signal bundle between the UART/sync-generator side and vga_pattern_ctrl.
// master drives the command/vblank inputs; slave is the controller.
interface vga_pattern_ctrl_if;
    logic       i_rx_dv;
    logic [7:0] i_rx_byte;
    logic       i_vblank;
    logic [2:0] o_pattern;
    logic [2:0] o_red;
    logic [2:0] o_grn;
    logic [2:0] o_blu;
    logic       o_auto;
    logic [7:0] o_frame_cnt;
    logic       o_frame_start;
    logic       o_cmd_err;
    logic       o_tx_dv;
    logic [7:0] o_tx_byte;

    modport master (
        output i_rx_dv, i_rx_byte, i_vblank,
        input  o_pattern, o_red, o_grn, o_blu, o_auto, o_frame_cnt,
        input  o_frame_start, o_cmd_err, o_tx_dv, o_tx_byte
    );

    modport slave (
        input  i_rx_dv, i_rx_byte, i_vblank,
        output o_pattern, o_red, o_grn, o_blu, o_auto, o_frame_cnt,
        output o_frame_start, o_cmd_err, o_tx_dv, o_tx_byte
    );
endinterface

// File: rtl/vga_pattern_ctrl.sv
// UART command decoder that stages pattern/colour/auto settings and commits them at vblank rise.
// Optional UART echo of accept/reject status: define VGA_PATTERN_CTRL_ECHO_EN.
module vga_pattern_ctrl #(
    parameter int unsigned NUM_PATTERNS = 4,
    parameter int unsigned AUTO_FRAMES  = 60
) (
    input logic               i_clk,
    input logic               i_rst,
    vga_pattern_ctrl_if.slave bus
);

    typedef enum logic {StIdle, StWaitArg} dec_state_e;
    typedef enum logic [1:0] {ChRed, ChGrn, ChBlu} chan_e;

    localparam logic [2:0] LastPat = 3'(NUM_PATTERNS - 1);
    localparam logic [7:0] LastCnt = 8'(AUTO_FRAMES - 1);

    dec_state_e state_q, state_d;
    chan_e      chan_q, chan_d;
    logic       pat_wr, auto_tgl, lvl_wr, cmd_err;
    logic       is_digit;
    logic [2:0] digit;

    logic       vb_q, frame_edge;
    logic [2:0] pat_p_q, red_p_q, grn_p_q, blu_p_q;
    logic       auto_p_q, manual_q;
    logic [7:0] auto_cnt_q, auto_cnt_d;
    logic [2:0] pat_next;

    logic [2:0] pattern_q, red_q, grn_q, blu_q;
    logic       auto_q, frame_start_q, cmd_err_q;
    logic [7:0] frame_cnt_q;

    assign is_digit   = (bus.i_rx_byte[7:3] == 5'b00110);
    assign digit      = bus.i_rx_byte[2:0];
    assign frame_edge = bus.i_vblank & ~vb_q;

    always_comb begin : decode
        state_d  = state_q;
        chan_d   = chan_q;
        pat_wr   = 1'b0;
        auto_tgl = 1'b0;
        lvl_wr   = 1'b0;
        cmd_err  = 1'b0;
        if (bus.i_rx_dv) begin
            unique case (state_q)
                StIdle: begin
                    if (is_digit) begin
                        if (32'(digit) < NUM_PATTERNS) pat_wr = 1'b1;
                        else                           cmd_err = 1'b1;
                    end else begin
                        case (bus.i_rx_byte)
                            8'h41: auto_tgl = 1'b1;
                            8'h52: begin chan_d = ChRed; state_d = StWaitArg; end
                            8'h47: begin chan_d = ChGrn; state_d = StWaitArg; end
                            8'h42: begin chan_d = ChBlu; state_d = StWaitArg; end
                            default: cmd_err = 1'b1;
                        endcase
                    end
                end
                StWaitArg: begin
                    state_d = StIdle;
                    if (is_digit) lvl_wr  = 1'b1;
                    else          cmd_err = 1'b1;
                end
            endcase
        end
    end

    // A pending manual select overrides the auto advance and restarts the frame count.
    always_comb begin : auto_step
        pat_next   = pat_p_q;
        auto_cnt_d = auto_cnt_q;
        if (frame_edge) begin
            if (!auto_p_q || manual_q) begin
                auto_cnt_d = '0;
            end else if (auto_cnt_q == LastCnt) begin
                auto_cnt_d = '0;
                pat_next   = (pat_p_q == LastPat) ? 3'd0 : pat_p_q + 3'd1;
            end else begin
                auto_cnt_d = auto_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin : dec_regs
        if (i_rst) begin
            state_q   <= StIdle;
            chan_q    <= ChRed;
            cmd_err_q <= 1'b0;
            vb_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            cmd_err_q <= cmd_err;
            vb_q      <= bus.i_vblank;
        end
    end

    // Byte writes come after the commit so a byte landing on a boundary goes to the next frame.
    always_ff @(posedge i_clk or posedge i_rst) begin : pending_regs
        if (i_rst) begin
            pat_p_q    <= 3'd0;
            red_p_q    <= 3'd7;
            grn_p_q    <= 3'd7;
            blu_p_q    <= 3'd7;
            auto_p_q   <= 1'b0;
            manual_q   <= 1'b0;
            auto_cnt_q <= 8'd0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
            if (frame_edge) begin
                pat_p_q  <= pat_next;
                manual_q <= 1'b0;
            end
            if (pat_wr) begin
                pat_p_q  <= digit;
                manual_q <= 1'b1;
            end
            if (auto_tgl) auto_p_q <= ~auto_p_q;
            if (lvl_wr) begin
                case (chan_q)
                    ChRed:   red_p_q <= digit;
                    ChGrn:   grn_p_q <= digit;
                    ChBlu:   blu_p_q <= digit;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin : active_regs
        if (i_rst) begin
            pattern_q     <= 3'd0;
            red_q         <= 3'd7;
            grn_q         <= 3'd7;
            blu_q         <= 3'd7;
            auto_q        <= 1'b0;
            frame_cnt_q   <= 8'd0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_edge;
            if (frame_edge) begin
                pattern_q   <= pat_next;
                red_q       <= red_p_q;
                grn_q       <= grn_p_q;
                blu_q       <= blu_p_q;
                auto_q      <= auto_p_q;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign bus.o_pattern     = pattern_q;
    assign bus.o_red         = red_q;
    assign bus.o_grn         = grn_q;
    assign bus.o_blu         = blu_q;
    assign bus.o_auto        = auto_q;
    assign bus.o_frame_cnt   = frame_cnt_q;
    assign bus.o_frame_start = frame_start_q;
    assign bus.o_cmd_err     = cmd_err_q;

`ifdef VGA_PATTERN_CTRL_ECHO_EN
    logic       tx_dv_q;
    logic [7:0] tx_byte_q;

    always_ff @(posedge i_clk or posedge i_rst) begin : echo_regs
        if (i_rst) begin
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            tx_dv_q <= bus.i_rx_dv;
            if (bus.i_rx_dv) tx_byte_q <= cmd_err ? 8'h3F : 8'h4B;
        end
    end

    assign bus.o_tx_dv   = tx_dv_q;
    assign bus.o_tx_byte = tx_byte_q;
`else
    assign bus.o_tx_dv   = 1'b0;
    assign bus.o_tx_byte = 8'h00;
`endif

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Randomised scoreboard bench for vga_pattern_ctrl against a behavioural command/frame model.
// The echo path is checked when VGA_PATTERN_CTRL_ECHO_EN is defined, otherwise it must stay 0.
module tb_vga_pattern_ctrl;

    localparam int NumPat = 4;
    localparam int AutoFr = 3;

    typedef struct packed {
        logic [2:0] pat;
        logic [2:0] red;
        logic [2:0] grn;
        logic [2:0] blu;
        logic       au;
        logic [7:0] fc;
    } outs_t;

    typedef struct packed {
        logic [31:0] cyc;
        outs_t       o;
    } commit_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  b;
    } tx_t;

    localparam outs_t ResetOuts = {3'd0, 3'd7, 3'd7, 3'd7, 1'b0, 8'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_pattern_ctrl_if bus ();

    vga_pattern_ctrl #(
        .NUM_PATTERNS(NumPat),
        .AUTO_FRAMES (AutoFr)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    commit_t commit_q[$];
    int      err_q[$];
    tx_t     tx_q[$];
    outs_t   exp_act;

    // Reference model state: what the controller should hold per the command rules.
    int    m_pend_pat, m_auto_p, m_manual, m_cnt, m_vb_prev, m_wait, m_chan;
    int    m_lvl[3];
    outs_t m_act;
    logic  vb_cur = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic outs_t cur_outs();
        return {bus.o_pattern, bus.o_red, bus.o_grn, bus.o_blu, bus.o_auto, bus.o_frame_cnt};
    endfunction

    task automatic model_reset();
        m_pend_pat = 0;
        m_auto_p   = 0;
        m_manual   = 0;
        m_cnt      = 0;
        m_vb_prev  = 0;
        m_wait     = 0;
        m_chan     = 0;
        m_lvl      = '{7, 7, 7};
        m_act      = ResetOuts;
        exp_act    = ResetOuts;
        commit_q.delete();
        err_q.delete();
        tx_q.delete();
    endtask

    // Predict the effect of one clock edge with the given inputs.
    task automatic model_step(input logic dv, input logic [7:0] b, input logic vb);
        commit_t c;
        tx_t     t;
        int      d;
        bit      is_dig;
        bit      ok;
        if (vb && !m_vb_prev) begin
            if (m_auto_p == 0 || m_manual != 0) begin
                m_cnt = 0;
            end else if (m_cnt == AutoFr - 1) begin
                m_cnt      = 0;
                m_pend_pat = (m_pend_pat + 1) % NumPat;
            end else begin
                m_cnt++;
            end
            m_manual  = 0;
            m_act.pat = 3'(m_pend_pat);
            m_act.red = 3'(m_lvl[0]);
            m_act.grn = 3'(m_lvl[1]);
            m_act.blu = 3'(m_lvl[2]);
            m_act.au  = (m_auto_p != 0);
            m_act.fc  = m_act.fc + 8'd1;
            c.cyc     = 32'(cyc + 1);
            c.o       = m_act;
            commit_q.push_back(c);
        end
        m_vb_prev = int'(vb);
        if (dv) begin
            d      = int'(b) - 48;
            is_dig = (b >= 8'h30 && b <= 8'h37);
            ok     = 1'b1;
            if (m_wait != 0) begin
                m_wait = 0;
                if (is_dig) m_lvl[m_chan] = d;
                else        ok = 1'b0;
            end else if (is_dig) begin
                if (d < NumPat) begin
                    m_pend_pat = d;
                    m_manual   = 1;
                end else begin
                    ok = 1'b0;
                end
            end else if (b == 8'h41) begin
                m_auto_p = (m_auto_p == 0) ? 1 : 0;
            end else if (b == 8'h52 || b == 8'h47 || b == 8'h42) begin
                m_wait = 1;
                m_chan = (b == 8'h52) ? 0 : (b == 8'h47) ? 1 : 2;
            end else begin
                ok = 1'b0;
            end
            if (!ok) err_q.push_back(cyc + 1);
`ifdef VGA_PATTERN_CTRL_ECHO_EN
            t.cyc = 32'(cyc + 1);
            t.b   = ok ? 8'h4B : 8'h3F;
            tx_q.push_back(t);
`else
            t = '0;
`endif
        end
    endtask

    task automatic step(input logic dv, input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.i_rx_dv   = dv;
        bus.i_rx_byte = b;
        bus.i_vblank  = vb_cur;
        model_step(dv, b, vb_cur);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic frame();
        vb_cur = 1'b1;
        idle(2);
        vb_cur = 1'b0;
        idle(6);
    endtask

    function automatic logic [7:0] rand_byte();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r <= 4) return 8'(8'h30 + $urandom_range(0, 7));
        if (r == 5) return 8'h41;
        if (r == 6) return 8'h52;
        if (r == 7) return 8'h47;
        if (r == 8) return 8'h42;
        return 8'($urandom_range(0, 255));
    endfunction

    // Monitor: pops an expectation whenever one is due this cycle and compares every output.
    always @(negedge clk) begin : monitor
        logic    exp_fs, exp_err, exp_tx;
        commit_t c;
        tx_t     t;
        int      e;
        if (!rst) begin
            exp_fs = (commit_q.size() > 0) && (commit_q[0].cyc == 32'(cyc));
            check("frame_start", 32'(bus.o_frame_start), 32'(exp_fs));
            if (exp_fs) begin
                c       = commit_q.pop_front();
                exp_act = c.o;
            end
            check("outputs", 32'(cur_outs()), 32'(exp_act));
            exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
            check("cmd_err", 32'(bus.o_cmd_err), 32'(exp_err));
            if (exp_err) e = err_q.pop_front();
`ifdef VGA_PATTERN_CTRL_ECHO_EN
            exp_tx = (tx_q.size() > 0) && (tx_q[0].cyc == 32'(cyc));
            check("tx_dv", 32'(bus.o_tx_dv), 32'(exp_tx));
            if (exp_tx) begin
                t = tx_q.pop_front();
                check("tx_byte", 32'(bus.o_tx_byte), 32'(t.b));
            end
`else
            exp_tx = 1'b0;
            check("tx_idle", 32'({bus.o_tx_dv, bus.o_tx_byte}), 32'({exp_tx, 8'h00}));
`endif
        end
    end

    initial begin : stimulus
        logic [2:0] held_pat;
        bus.i_rx_dv   = 1'b0;
        bus.i_rx_byte = 8'h00;
        bus.i_vblank  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outs", 32'(cur_outs()), 32'(ResetOuts));
        check("reset_pulses", 32'({bus.o_frame_start, bus.o_cmd_err}), 32'd0);

        repeat (3) frame();
        check("boot_frame_cnt", 32'(bus.o_frame_cnt), 32'd3);
        check("boot_pattern", 32'(bus.o_pattern), 32'd0);

        send(8'h32);
        idle(2);
        check("sel2_held", 32'(bus.o_pattern), 32'd0);
        frame();
        check("sel2_commit", 32'(bus.o_pattern), 32'd2);

        send(8'h47); send(8'h35); send(8'h42); send(8'h39); send(8'h52); send(8'h31);
        idle(1);
        frame();
        check("rgb_levels", 32'({bus.o_red, bus.o_grn, bus.o_blu}), 32'({3'd1, 3'd5, 3'd7}));

        send(8'h41);
        idle(1);
        repeat (13) frame();
        send(8'h31);
        idle(1);
        frame();
        check("auto_manual_sel", 32'(bus.o_pattern), 32'd1);
        repeat (5) frame();
        send(8'h41);
        frame();

        held_pat = bus.o_pattern;
        send(8'h35); send(8'h5A);
        idle(1);
        frame();
        check("bad_sel_pattern", 32'(bus.o_pattern), 32'(held_pat));

        for (int f = 0; f < 150; f++) begin
            int lo, hi;
            lo = int'($urandom_range(4, 16));
            hi = int'($urandom_range(1, 4));
            for (int c = 0; c < lo + hi; c++) begin
                vb_cur = (c >= lo);
                if ($urandom_range(0, 3) == 0) step(1'b1, rand_byte());
                else                           step(1'b0, 8'h00);
            end
        end

        vb_cur = 1'b0;
        idle(3);
        send(8'h00);
        idle(2);
        send(8'h52);
        idle(2);
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("midrst_outs", 32'(cur_outs()), 32'(ResetOuts));
        check("midrst_pulses", 32'({bus.o_frame_start, bus.o_cmd_err}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'h33);
        idle(1);
        frame();
        check("post_rst_sel3", 32'(bus.o_pattern), 32'd3);

        idle(4);
        check("commit_q_drained", 32'(commit_q.size()), 32'd0);
        check("err_q_drained", 32'(err_q.size()), 32'd0);
        check("tx_q_drained", 32'(tx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pattern_ctrl.md
Name: vga_pattern_ctrl

Overview:
UART-driven scheduler for the VGA pattern datapath. Decodes single- and two-byte command sequences from the UART receiver into pending settings: pattern select, per-channel colour level and auto-cycle enable. Commits pending settings only at frame boundaries, so the pixel path never changes mid-frame. Sits between the UART RX block and the pixel generator next to the sync generator, and supplies a frame count for the seven-segment display.

Parameters:
NUM_PATTERNS, 4, number of selectable patterns (1..8); pattern index wraps modulo this value.
AUTO_FRAMES, 60, frames between pattern advances in auto mode (2..255).

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_rx_dv  in  1  one-cycle strobe: i_rx_byte valid
i_rx_byte  in  8  received UART byte
i_vblank  in  1  vertical blank from sync generator (level)
o_pattern  out  3  active pattern index
o_red  out  3  active red level
o_grn  out  3  active green level
o_blu  out  3  active blue level
o_auto  out  1  active auto-cycle enable
o_frame_cnt  out  8  free-running frame counter, mod 256
o_frame_start  out  1  one-cycle pulse on rising edge of i_vblank
o_cmd_err  out  1  one-cycle pulse on rejected byte
o_tx_dv  out  1  echo strobe (see Optional Feature)
o_tx_byte  out  8  echo byte

Behaviour:
- Reset, asynchronous: active and pending pattern=0; red/grn/blu=7; auto=0; o_frame_cnt=0; auto counter=0; decoder state IDLE; vblank history register=0; all pulse outputs=0.
- Frame boundary: registered edge detect. o_frame_start=1 in the cycle after i_vblank is sampled 1 while the previous sample was 0. All commits happen on that same clock edge.
- Decoder FSM, states IDLE and WAIT_ARG. It acts only on cycles where i_rx_dv=1.
- IDLE, 0x30..0x37 ('0'..'7'): if value < NUM_PATTERNS, set pending pattern and set the manual-select flag. Otherwise pulse o_cmd_err.
- IDLE, 'A' (0x41): toggle pending auto.
- IDLE, 'R'/'G'/'B' (0x52/0x47/0x42): latch the channel and go to WAIT_ARG.
- IDLE, any other byte: pulse o_cmd_err and stay in IDLE.
- WAIT_ARG, 0x30..0x37: set the latched channel's pending level to the byte's low 3 bits and return to IDLE.
- WAIT_ARG, any other byte: pulse o_cmd_err, return to IDLE, discard the channel.
- WAIT_ARG has no timeout.
- Commit at frame boundary: active pattern/colour/auto take their pending values; o_frame_cnt increments, wrapping 255->0.
- Auto mode, with active auto=1 after the commit:
  - The auto counter increments each frame boundary.
  - When the counter equals AUTO_FRAMES-1 and the manual-select flag is clear: counter->0, pattern advances (NUM_PATTERNS-1 wraps to 0), and the pending pattern is set to the new value.
  - If the manual-select flag is set, the manual value wins and the counter->0.
  - The manual-select flag clears on every commit.
- With auto=0, the auto counter holds at 0.
- Simultaneous rx byte and frame boundary in the same cycle: the commit uses pending values from before that byte; the byte's effect lands in pending and commits at the next boundary.
- Output timing: outputs are registered and change only on commit edges (or reset). Latency from boundary detection to new outputs is 1 cycle.
- Reset mid-sequence, e.g. in WAIT_ARG: the partial command is dropped.

Optional Feature:
VGA_PATTERN_CTRL_ECHO_EN
- Defined: on each decoded byte, o_tx_dv pulses one cycle, 1 cycle after i_rx_dv. o_tx_byte = 0x4B ('K') on acceptance (including the first byte of R/G/B), or 0x3F ('?') on error, coincident with o_cmd_err.
- Undefined: o_tx_dv=0 and o_tx_byte=0 constantly; no echo logic.

Test Plan:
1. Reset, then 3 vblank edges -> pattern=0, r/g/b=7/7/7, auto=0, frame_cnt=3, err never pulses.
2. Send '2' mid-frame -> o_pattern stays 0 until the next vblank rise, then 2 exactly 1 cycle after that edge.
3. Send 'G','5' then 'B','9' -> grn=5 after the next boundary; '9' pulses o_cmd_err, FSM returns to IDLE, blu stays 7; then 'R','1' commits red=1.
4. Set AUTO_FRAMES=3, send 'A' -> after the commit, pattern steps 0->1->2->3->0 every 3 frames; send '1' mid-run -> next boundary pattern=1 and the counter restarts.
5. Send '5' with NUM_PATTERNS=4, then 'Z' -> two err pulses, pattern unchanged; with ECHO_EN, o_tx_byte=0x3F twice.
6. Assert i_rst in WAIT_ARG mid-frame -> all outputs return to reset values immediately; a following '3' is accepted as a pattern select.
